// File: rtl/instr_decode_stage.sv
// instr_decode_stage: buffered instruction-decode stage.
// A DEPTH-entry FIFO takes 16-bit instruction words over a valid/ready
// handshake. All decode fields come combinationally from the registered
// head entry, so there is no combinational path from input to output.
// Optional legality check: define DEC_ERR_CHECK_EN to flag illegal
// {opcode, op} encodings on err; when undefined, err is tied low.
module instr_decode_stage #(
   parameter int DW    = 16,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [15:0]              in_instr,
   input  logic [2:0]               nsel,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [2:0]               opcode,
   output logic [1:0]               op,
   output logic [1:0]               ALUop,
   output logic [1:0]               shift,
   output logic [DW-1:0]            sximm5,
   output logic [DW-1:0]            sximm8,
   output logic [2:0]               readnum,
   output logic [2:0]               writenum,
   output logic                     err,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

   logic [15:0]   mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push, pop;
   logic [15:0]   head;
   logic [2:0]    rn, rd, rm;

   // in_ready depends only on occupancy, so a pop never frees a slot early.
   assign in_ready  = (count_q < FULL_C);
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign count     = count_q;

   // Next-state for pointers and occupancy; pointers wrap as DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state: reset empties the FIFO immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; stale words are masked by out_valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_instr;
   end

   // Field extraction from the head; an empty FIFO decodes as all zeros.
   always_comb begin
      head     = out_valid ? mem_q[rd_ptr_q] : 16'h0000;
      opcode   = head[15:13];
      op       = head[12:11];
      ALUop    = head[12:11];
      shift    = head[4:3];
      rn       = head[10:8];
      rd       = head[7:5];
      rm       = head[2:0];
      sximm5   = DW'($signed(head[4:0]));
      sximm8   = DW'($signed(head[7:0]));
   end

   // Register select follows nsel directly; a non-one-hot nsel selects R0.
   always_comb begin
      readnum = 3'b000;
      case (nsel)
         3'b100:  readnum = rn;
         3'b010:  readnum = rd;
         3'b001:  readnum = rm;
         default: readnum = 3'b000;
      endcase
      writenum = readnum;
   end

`ifdef DEC_ERR_CHECK_EN
   // Legality check over {opcode, op}; only a valid head can be illegal.
   always_comb begin
      err = 1'b0;
      case ({opcode, op})
         5'b110_10, 5'b110_00,
         5'b101_00, 5'b101_01,
         5'b101_10, 5'b101_11: err = 1'b0;
         default:              err = out_valid;
      endcase
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed, table-driven bench for instr_decode_stage (DW=16, DEPTH=2).
module tb_instr_decode_stage;

   localparam int DW    = 16;
   localparam int DEPTH = 2;

`ifdef DEC_ERR_CHECK_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   localparam logic [15:0] W1 = 16'hD007; // 110_10_000_00000111
   localparam logic [15:0] W2 = 16'hD3FF; // 110_10_011_11111111
   localparam logic [15:0] W3 = 16'hA15D; // 101_00_001_010_11_101
   localparam logic [15:0] W4 = 16'hE000; // 111_00_000_00000000 (illegal)
   localparam logic [15:0] W5 = 16'hB9E2; // 101_11_001_111_00_010 (MVN)
   localparam logic [15:0] W6 = 16'hC8FF; // 110_01_000_111_11_111 (illegal)

   logic          clk = 1'b0;
   logic          reset_n;
   logic          in_valid;
   logic          in_ready;
   logic [15:0]   in_instr;
   logic [2:0]    nsel;
   logic          out_valid;
   logic          out_ready;
   logic [2:0]    opcode;
   logic [1:0]    op, ALUop, shift;
   logic [DW-1:0] sximm5, sximm8;
   logic [2:0]    readnum, writenum;
   logic          err;
   logic [1:0]    count;

   int n_tests = 0;
   int n_fail  = 0;

   instr_decode_stage #(.DW(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .nsel(nsel), .out_valid(out_valid), .out_ready(out_ready),
      .opcode(opcode), .op(op), .ALUop(ALUop), .shift(shift),
      .sximm5(sximm5), .sximm8(sximm8),
      .readnum(readnum), .writenum(writenum),
      .err(err), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic [15:0] instr;
      logic        ordy;
      logic [2:0]  nsel;
      logic [1:0]  cnt;
      logic        ov;
      logic        ir;
      logic [2:0]  opc;
      logic [1:0]  op;
      logic [1:0]  sh;
      logic [15:0] sx5;
      logic [15:0] sx8;
      logic [2:0]  rn;
      logic        er;
   } vec_t;

   vec_t vecs [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_outputs(input string tag, input logic [1:0] cnt, input logic ov,
                              input logic ir, input logic [2:0] opc, input logic [1:0] o,
                              input logic [1:0] sh, input logic [15:0] sx5,
                              input logic [15:0] sx8, input logic [2:0] rn, input logic er);
      chk({tag, ".count"},    32'(count),    32'(cnt));
      chk({tag, ".out_valid"},32'(out_valid),32'(ov));
      chk({tag, ".in_ready"}, 32'(in_ready), 32'(ir));
      chk({tag, ".opcode"},   32'(opcode),   32'(opc));
      chk({tag, ".op"},       32'(op),       32'(o));
      chk({tag, ".ALUop"},    32'(ALUop),    32'(o));
      chk({tag, ".shift"},    32'(shift),    32'(sh));
      chk({tag, ".sximm5"},   32'(sximm5),   32'(sx5));
      chk({tag, ".sximm8"},   32'(sximm8),   32'(sx8));
      chk({tag, ".readnum"},  32'(readnum),  32'(rn));
      chk({tag, ".writenum"}, 32'(writenum), 32'(rn));
      chk({tag, ".err"},      32'(err),      32'(er));
   endtask

   initial begin
      //          iv  instr ordy nsel    cnt ov ir opc     op     sh     sx5      sx8      rn    er
      vecs[0]  = '{1'b1, W1, 1'b0, 3'b100, 2'd1, 1, 1, 3'b110, 2'b10, 2'b00, 16'h0007, 16'h0007, 3'd0, 1'b0};
      vecs[1]  = '{1'b0, W1, 1'b1, 3'b100, 2'd0, 0, 1, 3'b000, 2'b00, 2'b00, 16'h0000, 16'h0000, 3'd0, 1'b0};
      vecs[2]  = '{1'b0, W1, 1'b1, 3'b100, 2'd0, 0, 1, 3'b000, 2'b00, 2'b00, 16'h0000, 16'h0000, 3'd0, 1'b0};
      vecs[3]  = '{1'b1, W2, 1'b0, 3'b100, 2'd1, 1, 1, 3'b110, 2'b10, 2'b11, 16'hFFFF, 16'hFFFF, 3'd3, 1'b0};
      vecs[4]  = '{1'b1, W3, 1'b0, 3'b100, 2'd2, 1, 0, 3'b110, 2'b10, 2'b11, 16'hFFFF, 16'hFFFF, 3'd3, 1'b0};
      vecs[5]  = '{1'b1, W4, 1'b0, 3'b001, 2'd2, 1, 0, 3'b110, 2'b10, 2'b11, 16'hFFFF, 16'hFFFF, 3'd7, 1'b0};
      vecs[6]  = '{1'b0, W4, 1'b1, 3'b001, 2'd1, 1, 1, 3'b101, 2'b00, 2'b11, 16'hFFFD, 16'h005D, 3'd5, 1'b0};
      vecs[7]  = '{1'b1, W5, 1'b1, 3'b010, 2'd1, 1, 1, 3'b101, 2'b11, 2'b00, 16'h0002, 16'hFFE2, 3'd7, 1'b0};
      vecs[8]  = '{1'b1, W4, 1'b0, 3'b010, 2'd2, 1, 0, 3'b101, 2'b11, 2'b00, 16'h0002, 16'hFFE2, 3'd7, 1'b0};
      vecs[9]  = '{1'b1, W1, 1'b1, 3'b100, 2'd1, 1, 1, 3'b111, 2'b00, 2'b00, 16'h0000, 16'h0000, 3'd0, ERR_EXP};
      vecs[10] = '{1'b0, W1, 1'b1, 3'b100, 2'd0, 0, 1, 3'b000, 2'b00, 2'b00, 16'h0000, 16'h0000, 3'd0, 1'b0};
      vecs[11] = '{1'b1, W6, 1'b0, 3'b011, 2'd1, 1, 1, 3'b110, 2'b01, 2'b11, 16'hFFFF, 16'hFFFF, 3'd0, ERR_EXP};
      vecs[12] = '{1'b0, W6, 1'b0, 3'b010, 2'd1, 1, 1, 3'b110, 2'b01, 2'b11, 16'hFFFF, 16'hFFFF, 3'd7, ERR_EXP};
      vecs[13] = '{1'b0, W6, 1'b0, 3'b001, 2'd1, 1, 1, 3'b110, 2'b01, 2'b11, 16'hFFFF, 16'hFFFF, 3'd7, ERR_EXP};
      vecs[14] = '{1'b1, W3, 1'b1, 3'b010, 2'd1, 1, 1, 3'b101, 2'b00, 2'b11, 16'hFFFD, 16'h005D, 3'd2, 1'b0};
      vecs[15] = '{1'b1, W2, 1'b0, 3'b010, 2'd2, 1, 0, 3'b101, 2'b00, 2'b11, 16'hFFFD, 16'h005D, 3'd2, 1'b0};

      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_instr  = 16'h0000;
      out_ready = 1'b0;
      nsel      = 3'b100;
      repeat (2) @(negedge clk);
      chk_outputs("reset", 2'd0, 1'b0, 1'b1, 3'b000, 2'b00, 2'b00, 16'h0000, 16'h0000, 3'd0, 1'b0);
      reset_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 16; i++) begin
         in_valid  = vecs[i].iv;
         in_instr  = vecs[i].instr;
         out_ready = vecs[i].ordy;
         nsel      = vecs[i].nsel;
         @(negedge clk);
         chk_outputs($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ov, vecs[i].ir,
                     vecs[i].opc, vecs[i].op, vecs[i].sh, vecs[i].sx5, vecs[i].sx8,
                     vecs[i].rn, vecs[i].er);
      end

      // Mid-stream reset with two entries held: must clear between edges.
      in_valid  = 1'b0;
      out_ready = 1'b0;
      nsel      = 3'b010;
      #2 reset_n = 1'b0;
      #1;
      chk_outputs("midrst", 2'd0, 1'b0, 1'b1, 3'b000, 2'b00, 2'b00, 16'h0000, 16'h0000, 3'd0, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk_outputs("postrst", 2'd0, 1'b0, 1'b1, 3'b000, 2'b00, 2'b00, 16'h0000, 16'h0000, 3'd0, 1'b0);

      // No combinational in->out path: output appears only after the edge.
      in_valid = 1'b1;
      in_instr = W1;
      nsel     = 3'b100;
      #2;
      chk("latency.pre_out_valid", 32'(out_valid), 32'd0);
      chk("latency.pre_opcode",    32'(opcode),    32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      chk_outputs("latency", 2'd1, 1'b1, 1'b1, 3'b110, 2'b10, 2'b00, 16'h0007, 16'h0007, 3'd0, 1'b0);

      // Drain: afterwards the empty head decodes to zero.
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk_outputs("drain", 2'd0, 1'b0, 1'b1, 3'b000, 2'b00, 2'b00, 16'h0000, 16'h0000, 3'd0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_decode_stage.md
# instr_decode_stage

Buffered, parametrised instruction-decode stage for the Simple RISC Machine. It accepts 16-bit instruction words from the instruction register over a valid/ready handshake and holds them in a DEPTH-entry FIFO. It presents the decoded fields of the head entry to the FSM controller and datapath. It generalises the combinational decoder with datapath-width sign extension, buffering, back-pressure and legality checking.

## Interface
Parameters:
- DW, 16: datapath width; width of sximm5/sximm8 (must be ≥ 8).
- DEPTH, 2: FIFO entries; power of two, ≥ 2.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  in_instr is valid this cycle
- in_ready  output  1  stage can accept an instruction
- in_instr  input  16  instruction word
- nsel  input  3  one-hot register select: 100 = Rn, 010 = Rd, 001 = Rm
- out_valid  output  1  head entry is valid
- out_ready  input  1  consumer (FSM) retires head entry
- opcode  output  3  head[15:13]
- op  output  2  head[12:11]
- ALUop  output  2  head[12:11]
- shift  output  2  head[4:3]
- sximm5  output  DW  head[4:0], sign-extended
- sximm8  output  DW  head[7:0], sign-extended
- readnum, writenum  output  3  register selected by nsel
- err  output  1  head entry is an illegal encoding
- count  output  $clog2(DEPTH)+1  occupancy

## Operation
- Push: in_valid && in_ready. Pop: out_valid && out_ready.
- in_ready = (count < DEPTH). A push is refused when the FIFO is full, even if a pop occurs in the same cycle.
- Pointers wrap modulo DEPTH. count increments on push-only, decrements on pop-only, and is unchanged on simultaneous push+pop.
- All decode outputs are combinational from the registered head entry. When out_valid=0 the head is treated as 16'h0000, so all fields are 0 and err=0.
- Fields: Rn = head[10:8], Rd = head[7:5], Rm = head[2:0].
- Sign extension: sximm8 = {{(DW-8){head[7]}}, head[7:0]} and sximm5 = {{(DW-5){head[4]}}, head[4:0]}.
- readnum = writenum = Rn, Rd or Rm according to nsel. If nsel is not one-hot, both are 3'b000.
- Legal encodings, as {opcode, op}:
  - 110_10: MOV Rn,#imm8
  - 110_00: MOV Rd,Rm{,sh}
  - 101_00: ADD
  - 101_01: CMP
  - 101_10: AND
  - 101_11: MVN
- Illegal entries are still delivered in order and must still be popped.

## Timing
- Reset (async assert, deassert sync to clk):
  - count=0, pointers=0, out_valid=0, in_ready=1.
  - All decode outputs = 0; err=0.
  - Storage contents are don't-care.
- Latency: an instruction pushed at edge N is visible on the outputs after edge N (the same cycle as count=1). There is no combinational in→out path.
- in_ready depends only on count, never on out_ready.
- Empty: a pop is ignored. Full: a push is ignored and in_ready=0.
- Reset asserted mid-stream discards all entries immediately, without waiting for a clock edge.
- nsel changes take effect on readnum/writenum in the same cycle (combinational).

## Configuration
- DEC_ERR_CHECK_EN defined: err = head is valid and {opcode, op} is not one of the six legal encodings.
- Macro undefined: err is tied to 1'b0 and the legality logic is not synthesised. All other behaviour is identical.

## Test plan
- MOV immediate:
  - Stimulus: reset, then push 16'b110_10_000_00000111 with nsel=100.
  - Response: next cycle out_valid=1, opcode=110, op=10, readnum=0, sximm8=16'h0007, err=0.
- Negative immediates:
  - Stimulus: push 16'b110_10_011_11111111, then 16'b101_00_001_010_11_101 with nsel=001.
  - Response: first entry gives sximm8=16'hFFFF. After pop, second gives ALUop=00, shift=11, sximm5=16'hFFFD, readnum=5.
- Back-pressure and ordering:
  - Stimulus: out_ready=0, push 3 words with DEPTH=2.
  - Response: in_ready=0 after the 2nd push, 3rd is refused, count=2. Draining yields words 1 and 2 in order, then out_valid=0 and all outputs = 0.
- Simultaneous push+pop:
  - Stimulus: count=1, push and pop in the same cycle.
  - Response: count stays 1 and the head becomes the new word. When full, a push with pop is refused and count drops to 1.
- Illegal opcode:
  - Stimulus: push 16'b111_00_000_00000000.
  - Response: err=1 with DEC_ERR_CHECK_EN defined, err=0 without it. The entry is still popped normally.
- Reset mid-stream:
  - Stimulus: count=2, pulse reset_n low between clock edges.
  - Response: immediately count=0, out_valid=0, in_ready=1, all outputs 0.
